// File: rtl/bip_pkg.sv
// Shared widths, accumulator-source and ALU-op encodings, and small helpers
// used by the accumulator datapath and its data memory.
package bip_pkg;

    localparam int DATA_W    = 16;
    localparam int OPND_W    = 11;
    localparam int MAX_DEPTH = 2048;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OPND_W-1:0] opnd_t;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'b00,
        SRC_IMM  = 2'b01,
        SRC_ALU  = 2'b10,
        SRC_HOLD = 2'b11
    } sel_a_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    function automatic data_t sign_extend(opnd_t v);
        return {{(DATA_W-OPND_W){v[OPND_W-1]}}, v};
    endfunction

    // Subtraction overflows exactly like addition of an operand with inverted sign.
    function automatic logic add_sub_ovf(data_t a, data_t b, data_t r, alu_op_e op);
        logic b_sign;
        b_sign = (op == OP_SUB) ? ~b[DATA_W-1] : b[DATA_W-1];
        return (a[DATA_W-1] == b_sign) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/bip_datapath_if.sv
// Control-word, status and debug-port bundle between a sequencer and bip_datapath.
interface bip_datapath_if import bip_pkg::*; ();

    logic       ENABLE;
    logic [1:0] SEL_A;
    logic       SEL_B;
    logic       WR_ACC;
    logic       OP;
    logic       WR_RAM;
    logic       RD_RAM;
    opnd_t      OPERAND;
    data_t      ACC;
    logic       OVF;
    data_t      CYCLE_COUNT;
    opnd_t      DBG_ADDR;
    data_t      DBG_DATA;

    modport master (
        output ENABLE, SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, OPERAND, DBG_ADDR,
        input  ACC, OVF, CYCLE_COUNT, DBG_DATA
    );

    modport slave (
        input  ENABLE, SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM, OPERAND, DBG_ADDR,
        output ACC, OVF, CYCLE_COUNT, DBG_DATA
    );

endinterface

// File: rtl/bip_data_ram.sv
// Data memory: one synchronous write port and two asynchronous read ports;
// addresses at or beyond RAM_DEPTH are ignored on write and read as zero.
module bip_data_ram import bip_pkg::*; #(
    parameter int RAM_DEPTH = 1024
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  opnd_t waddr,
    input  data_t wdata,
    input  opnd_t raddr_a,
    output data_t rdata_a,
    input  opnd_t raddr_b,
    output data_t rdata_b
);

    localparam int AW = $clog2(RAM_DEPTH);

    data_t mem [RAM_DEPTH];

    function automatic logic in_range(opnd_t a);
        return int'(a) < RAM_DEPTH;
    endfunction

    // NOTE: storage arrays carry no reset; resetting them would turn the RAM into flops.
    // Gating with rst_n drops a write that lands on an edge while reset is held.
    always_ff @(posedge clk) begin
        if (we && rst_n && in_range(waddr)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata_a = in_range(raddr_a) ? mem[raddr_a[AW-1:0]] : '0;
    assign rdata_b = in_range(raddr_b) ? mem[raddr_b[AW-1:0]] : '0;

endmodule

// File: rtl/bip_datapath.sv
// Single-accumulator datapath: immediate/memory operand select, add/sub ALU,
// accumulator with sticky signed overflow, saturating executed-cycle counter.
module bip_datapath import bip_pkg::*; #(
    parameter int RAM_DEPTH = 1024
) (
    input logic           CLK,
    input logic           RESET,
    bip_datapath_if.slave bus
);

    data_t   acc_q, acc_d;
    logic    ovf_q, ovf_d;
    data_t   cnt_q, cnt_d;

    data_t   imm;
    data_t   ram_rd;
    data_t   mem_val;
    data_t   opnd_b;
    data_t   alu_res;
    logic    alu_ovf;
    alu_op_e alu_op;
    data_t   dbg_data;
    logic    ram_we;

    assign ram_we = bus.ENABLE & bus.WR_RAM;

    // Write data is the accumulator as it stands before the edge.
    bip_data_ram #(.RAM_DEPTH(RAM_DEPTH)) u_ram (
        .clk     (CLK),
        .rst_n   (RESET),
        .we      (ram_we),
        .waddr   (bus.OPERAND),
        .wdata   (acc_q),
        .raddr_a (bus.OPERAND),
        .rdata_a (ram_rd),
        .raddr_b (bus.DBG_ADDR),
        .rdata_b (dbg_data)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        alu_op  = alu_op_e'(bus.OP);
        imm     = sign_extend(bus.OPERAND);
        mem_val = bus.RD_RAM ? ram_rd : '0;
        opnd_b  = bus.SEL_B ? imm : mem_val;
        alu_res = (alu_op == OP_SUB) ? acc_q - opnd_b : acc_q + opnd_b;
        alu_ovf = add_sub_ovf(acc_q, opnd_b, alu_res, alu_op);

        if (bus.ENABLE) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
            if (bus.WR_ACC) begin
                case (sel_a_e'(bus.SEL_A))
                    SRC_MEM:  acc_d = mem_val;
                    SRC_IMM:  acc_d = imm;
                    SRC_ALU: begin
                        acc_d = alu_res;
                        ovf_d = ovf_q | alu_ovf;
                    end
                    default:  acc_d = acc_q;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ACC         = acc_q;
    assign bus.OVF         = ovf_q;
    assign bus.CYCLE_COUNT = cnt_q;
    assign bus.DBG_DATA    = dbg_data;

endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: directed scenarios plus randomized
// control words scored against an arithmetic reference model.
module tb_bip_datapath;

    localparam int DEPTH = 1024;

    logic CLK = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [15:0] acc_m;
    logic        ovf_m;
    logic [15:0] cnt_m;
    logic [15:0] mem_m   [0:2047];
    bit          mem_vld [0:2047];

    bip_datapath_if bus ();

    bip_datapath #(.RAM_DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_state(input string tag);
        checks++;
        if (bus.ACC !== acc_m) begin
            errors++;
            $display("FAIL %s acc: got %h want %h", tag, bus.ACC, acc_m);
        end
        checks++;
        if (bus.OVF !== ovf_m) begin
            errors++;
            $display("FAIL %s ovf: got %b want %b", tag, bus.OVF, ovf_m);
        end
        checks++;
        if (bus.CYCLE_COUNT !== cnt_m) begin
            errors++;
            $display("FAIL %s cycle_count: got %h want %h", tag, bus.CYCLE_COUNT, cnt_m);
        end
    endtask

    task automatic check_dbg(input logic [10:0] addr, input logic [15:0] want, input string tag);
        bus.DBG_ADDR = addr;
        #1;
        checks++;
        if (bus.DBG_DATA !== want) begin
            errors++;
            $display("FAIL %s dbg[%0d]: got %h want %h", tag, addr, bus.DBG_DATA, want);
        end
    endtask

    // One executed control word: model predicts, clock edge, compare.
    task automatic step(input logic en, input logic [1:0] sa, input logic sb, input logic wacc,
                        input logic op, input logic wram, input logic rram,
                        input logic [10:0] opnd, input string tag);
        logic [15:0] rd_v, imm_v, b_v;
        int          a_s, b_s, r_s, imm_i;
        logic        in_rng;
        bus.ENABLE  = en;
        bus.SEL_A   = sa;
        bus.SEL_B   = sb;
        bus.WR_ACC  = wacc;
        bus.OP      = op;
        bus.WR_RAM  = wram;
        bus.RD_RAM  = rram;
        bus.OPERAND = opnd;
        in_rng = int'(opnd) < DEPTH;
        rd_v   = (rram && in_rng) ? mem_m[opnd] : 16'h0000;
        imm_i  = $signed(opnd);
        imm_v  = 16'(imm_i);
        b_v    = sb ? imm_v : rd_v;
        a_s    = $signed(acc_m);
        b_s    = $signed(b_v);
        r_s    = op ? a_s - b_s : a_s + b_s;
        if (en) begin
            if (wram && in_rng) begin
                mem_m[opnd]   = acc_m;
                mem_vld[opnd] = 1'b1;
            end
            if (wacc) begin
                case (sa)
                    2'd0: acc_m = rd_v;
                    2'd1: acc_m = imm_v;
                    2'd2: begin
                        acc_m = 16'(r_s);
                        if (r_s > 32767 || r_s < -32768) ovf_m = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
        @(posedge CLK);
        #1;
        check_state(tag);
    endtask

    task automatic load_imm(input logic [10:0] v);
        step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v, "load_imm");
    endtask

    // Double ACC by storing it to scratch address 20 and adding it back.
    task automatic double_acc();
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd20, "dbl_store");
        step(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd20, "dbl_add");
    endtask

    task automatic apply_reset(input string tag);
        RESET = 1'b0;
        #1;
        acc_m = 16'h0000;
        ovf_m = 1'b0;
        cnt_m = 16'h0000;
        check_state(tag);
        @(negedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        bus.ENABLE   = 1'b0;
        bus.SEL_A    = 2'b11;
        bus.SEL_B    = 1'b0;
        bus.WR_ACC   = 1'b0;
        bus.OP       = 1'b0;
        bus.WR_RAM   = 1'b0;
        bus.RD_RAM   = 1'b0;
        bus.OPERAND  = 11'd0;
        bus.DBG_ADDR = 11'd0;
        apply_reset("reset");
    endtask

    task automatic test_imm_load();
        load_imm(11'h7FF);
        checks++;
        if (bus.ACC !== 16'hFFFF || bus.CYCLE_COUNT !== 16'd1) begin
            errors++;
            $display("FAIL imm_load: acc=%h cnt=%0d want acc=ffff cnt=1", bus.ACC, bus.CYCLE_COUNT);
        end
    endtask

    task automatic test_mem_roundtrip();
        load_imm(11'd5);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd3, "store5");
        load_imm(11'd0);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd3, "read5");
        checks++;
        if (bus.ACC !== 16'd5) begin
            errors++;
            $display("FAIL mem_read: acc=%h want 0005", bus.ACC);
        end
        check_dbg(11'd3, 16'd5, "dbg_after_store");
        // Read and write of the same address in one cycle returns the old word.
        load_imm(11'd7);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd3, "raw_same_addr");
        checks++;
        if (bus.ACC !== 16'd5) begin
            errors++;
            $display("FAIL read_old_contents: acc=%h want 0005", bus.ACC);
        end
        check_dbg(11'd3, 16'd7, "dbg_new_contents");
    endtask

    task automatic test_overflow();
        load_imm(11'h3FF);
        for (int i = 0; i < 5; i++) double_acc();
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h01F, "to_7fff");
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, "add_ovf");
        checks++;
        if (bus.ACC !== 16'h8000 || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: acc=%h ovf=%b want 8000/1", bus.ACC, bus.OVF);
        end
        load_imm(11'd0);
        checks++;
        if (bus.ACC !== 16'h0000 || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: acc=%h ovf=%b want 0000/1", bus.ACC, bus.OVF);
        end
        // Subtract overflow from a clean state: -32768 - 1.
        apply_reset("reset_sub");
        load_imm(11'h400);
        for (int i = 0; i < 5; i++) double_acc();
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h001, "sub_ovf");
        checks++;
        if (bus.ACC !== 16'h7FFF || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL sub_overflow: acc=%h ovf=%b want 7fff/1", bus.ACC, bus.OVF);
        end
    endtask

    task automatic test_simul_write();
        load_imm(11'd9);
        step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, "store_and_load");
        checks++;
        if (bus.ACC !== 16'd2) begin
            errors++;
            $display("FAIL simul_acc: acc=%h want 0002", bus.ACC);
        end
        check_dbg(11'd2, 16'd9, "simul_ram");
    endtask

    task automatic test_freeze_and_range();
        logic [15:0] cnt_before;
        cnt_before = cnt_m;
        for (int i = 0; i < 4; i++)
            step(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, "frozen");
        checks++;
        if (bus.ACC !== 16'd2 || bus.CYCLE_COUNT !== cnt_before) begin
            errors++;
            $display("FAIL freeze: acc=%h cnt=%0d want 0002/%0d", bus.ACC, bus.CYCLE_COUNT, cnt_before);
        end
        check_dbg(11'd2, 16'd9, "freeze_ram");
        // 1500 aliases to 476 if the upper address bits were dropped.
        load_imm(11'd44);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd476, "store476");
        load_imm(11'd99);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1500, "store_oor");
        check_dbg(11'd1500, 16'd0, "dbg_oor");
        check_dbg(11'd476, 16'd44, "no_alias");
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd1500, "read_oor");
        checks++;
        if (bus.ACC !== 16'd0) begin
            errors++;
            $display("FAIL read_oor: acc=%h want 0000", bus.ACC);
        end
        load_imm(11'd321);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1023, "store_last");
        check_dbg(11'd1023, 16'd321, "dbg_last");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1024, "store_first_oor");
        check_dbg(11'd1024, 16'd0, "dbg_first_oor");
        check_dbg(11'd0, 16'd0, "dbg_zero_untouched");
    endtask

    task automatic test_reset_mid();
        apply_reset("reset_pre");
        load_imm(11'h234);
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h200, "build_1234");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd7, "store_1234");
        checks++;
        if (bus.ACC !== 16'h1234 || bus.CYCLE_COUNT !== 16'd10) begin
            errors++;
            $display("FAIL pre_reset: acc=%h cnt=%0d want 1234/10", bus.ACC, bus.CYCLE_COUNT);
        end
        // Pending store of the (now zero) ACC to address 7 must be dropped.
        bus.ENABLE = 1'b1;
        bus.WR_RAM = 1'b1;
        bus.WR_ACC = 1'b1;
        bus.SEL_A  = 2'b01;
        bus.OPERAND = 11'd7;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.ACC !== 16'h0000 || bus.CYCLE_COUNT !== 16'd0 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: acc=%h cnt=%0d ovf=%b want 0/0/0", bus.ACC, bus.CYCLE_COUNT, bus.OVF);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.ACC !== 16'h0000 || bus.CYCLE_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold: acc=%h cnt=%0d want 0/0", bus.ACC, bus.CYCLE_COUNT);
        end
        @(negedge CLK);
        #1;
        bus.ENABLE = 1'b0;
        bus.WR_RAM = 1'b0;
        RESET = 1'b1;
        acc_m = 16'h0000;
        ovf_m = 1'b0;
        cnt_m = 16'h0000;
        check_dbg(11'd7, 16'h1234, "ram_kept");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, "first_after_reset");
    endtask

    task automatic test_random();
        logic [10:0] a;
        logic        rram, wram;
        apply_reset("reset_rand");
        for (int i = 0; i < 16; i++) begin
            load_imm(11'($urandom_range(0, 2047)));
            step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'(i), "rand_init");
        end
        for (int n = 0; n < 400; n++) begin
            rram = 1'($urandom_range(0, 1));
            wram = ($urandom_range(0, 3) == 0);
            if (rram || wram)
                a = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(1024, 2047))
                                                : 11'($urandom_range(0, 15));
            else
                a = 11'($urandom_range(0, 2047));
            step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wram, rram, a, "random");
            if ((n % 8) == 0) begin
                a = 11'($urandom_range(0, 15));
                check_dbg(a, mem_m[a], "rand_dbg");
            end
        end
    endtask

    initial begin
        RESET = 1'b0;
        test_reset();
        test_imm_load();
        test_mem_roundtrip();
        test_overflow();
        test_simul_write();
        test_freeze_and_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bip_datapath.md
BIP_DATAPATH -- requirements
Module: bip_datapath

Interface
REQ-001 SHALL expose parameter RAM_DEPTH, default 1024, meaning number of 16-bit data-memory words (power of two, max 2048).
REQ-002 SHALL expose: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL expose: RESET  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL expose: ENABLE  input  1  1 = execute current control word; 0 = halted, all state frozen.
REQ-005 SHALL expose: SEL_A  input  2  accumulator source select.
REQ-006 SHALL expose: SEL_B  input  1  ALU operand-B select.
REQ-007 SHALL expose: WR_ACC  input  1  accumulator write enable.
REQ-008 SHALL expose: OP  input  1  ALU operation, 0 = add, 1 = subtract.
REQ-009 SHALL expose: WR_RAM / RD_RAM  input  1 each  data-memory write / read enables.
REQ-010 SHALL expose: OPERAND  input  11  immediate value or data-memory address.
REQ-011 SHALL expose: ACC  output  16  current accumulator value.
REQ-012 SHALL expose: OVF  output  1  sticky signed-overflow flag.
REQ-013 SHALL expose: CYCLE_COUNT  output  16  executed-cycle counter.
REQ-014 SHALL expose: DBG_ADDR  input  11 / DBG_DATA  output  16  debug read port into data memory.

Function
REQ-015 Immediate SHALL be OPERAND sign-extended to 16 bits.
REQ-016 Memory read value SHALL be RAM[OPERAND] combinationally when RD_RAM=1 and address in range, else 16'h0000.
REQ-017 Operand B SHALL be memory read value when SEL_B=0, immediate when SEL_B=1.
REQ-018 ALU result SHALL be ACC+B (OP=0) or ACC-B (OP=1), 16-bit two's complement, wrapping modulo 2^16.
REQ-019 ACC next value SHALL be: SEL_A=00 memory read value; 01 immediate; 10 ALU result; 11 ACC unchanged.
REQ-020 ACC SHALL update on the rising edge only when ENABLE=1 and WR_ACC=1; latency one cycle.
REQ-021 Data memory SHALL write ACC (pre-edge value) to RAM[OPERAND] on rising edge when ENABLE=1, WR_RAM=1, address in range.
REQ-022 Address >= RAM_DEPTH SHALL suppress writes and return 0 on reads (both ports); no other side effect.
REQ-023 Simultaneous WR_RAM and WR_ACC SHALL store the old ACC and load the new ACC in the same edge.
REQ-024 WR_RAM and RD_RAM to the same address in one cycle SHALL read the old (pre-write) contents.
REQ-025 OVF SHALL set when ENABLE=1, WR_ACC=1, SEL_A=10 and the signed add/sub overflows; cleared only by reset.
REQ-026 CYCLE_COUNT SHALL increment by 1 on each rising edge with ENABLE=1 and saturate at 16'hFFFF.
REQ-027 ENABLE=0 SHALL freeze ACC, OVF, CYCLE_COUNT and memory regardless of other inputs.
REQ-028 DBG_DATA SHALL be RAM[DBG_ADDR] combinationally, independent of ENABLE and RD_RAM.

Reset
REQ-029 RESET=0 SHALL immediately force ACC=0, OVF=0, CYCLE_COUNT=0, independent of CLK.
REQ-030 Data-memory contents SHALL NOT be reset; undefined until written.
REQ-031 Reset asserted mid-operation SHALL discard any pending write on that edge; first update follows first rising edge after RESET=1.

Structure
REQ-032 Shared package bip_pkg SHALL hold data width (16), operand width (11), SEL_A encodings (SRC_MEM, SRC_IMM, SRC_ALU, SRC_HOLD) and OP encodings (OP_ADD, OP_SUB).
REQ-033 Data memory SHALL be one sub-module bip_data_ram: single write port, two asynchronous read ports, parameterised by RAM_DEPTH.
REQ-034 Sign-extension, B mux, ALU, ACC register, OVF and counter SHALL reside in bip_datapath.

Verification
REQ-035 Reset, ENABLE=1, SEL_A=01 WR_ACC=1 OPERAND=11'h7FF -> ACC=16'hFFFF after one edge; CYCLE_COUNT=1.
REQ-036 ACC=5, WR_RAM=1 OPERAND=3; then SEL_A=00 RD_RAM=1 WR_ACC=1 OPERAND=3 after loading ACC=0 -> ACC=5; DBG_ADDR=3 -> DBG_DATA=5.
REQ-037 ACC=16'h7FFF, SEL_A=10 SEL_B=1 OP=0 OPERAND=1 WR_ACC=1 -> ACC=16'h8000, OVF=1; later ACC=0 load leaves OVF=1.
REQ-038 ACC=9, WR_RAM=1 plus SEL_A=01 OPERAND=2 WR_ACC=1 same cycle -> RAM[addr]=9, ACC=2.
REQ-039 ENABLE=0 with WR_ACC=1 WR_RAM=1 for 4 cycles -> ACC, RAM, CYCLE_COUNT unchanged; OPERAND=1500 (RAM_DEPTH=1024) write ignored, read returns 0.
REQ-040 RESET pulsed low between edges with ACC=16'h1234, CYCLE_COUNT=10 -> ACC=0, CYCLE_COUNT=0, OVF=0 immediately; RAM contents preserved.
